// File: rtl/ip_cu_ctrl_if.sv
// ----------------------------------------------------------------------------
// ip_cu_ctrl_if -- handshake and strobe bundle between a CU requester and
// the ip_cu_ctrl sequencer.
//
// Signals:
//   cu_req      requester -> ctrl  operation request (level, held until done)
//   cu_op       requester -> ctrl  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV
//   cu_done     ctrl -> requester  one-cycle pulse, datapath product valid
//   cu_busy     ctrl -> requester  high whenever the sequencer is not idle
//   op_*_sm     ctrl -> datapath   state strobes (ini / act / rdy / halt)
//   *_en        ctrl -> datapath   one-hot operation enables
//   cu_abort    requester -> ctrl  abort request   (IP_CU_CTRL_ABORT_EN only)
//   cu_abt      ctrl -> requester  abort pulse      (IP_CU_CTRL_ABORT_EN only)
//
// Modports: master = requester side, slave = ip_cu_ctrl side.
// Optional macro: IP_CU_CTRL_ABORT_EN adds the cu_abort / cu_abt pair.
// ----------------------------------------------------------------------------
interface ip_cu_ctrl_if;

    logic       cu_req;
    logic [1:0] cu_op;
    logic       cu_done;
    logic       cu_busy;
    logic       op_ini_sm;
    logic       op_act_sm;
    logic       op_rdy_sm;
    logic       op_halt_sm;
    logic       add_en;
    logic       sub_en;
    logic       mul_en;
    logic       div_en;
`ifdef IP_CU_CTRL_ABORT_EN
    logic       cu_abort;
    logic       cu_abt;
`endif

`ifdef IP_CU_CTRL_ABORT_EN
    modport master (
        output cu_req, cu_op, cu_abort,
        input  cu_done, cu_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
               add_en, sub_en, mul_en, div_en, cu_abt
    );

    modport slave (
        input  cu_req, cu_op, cu_abort,
        output cu_done, cu_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
               add_en, sub_en, mul_en, div_en, cu_abt
    );
`else
    modport master (
        output cu_req, cu_op,
        input  cu_done, cu_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
               add_en, sub_en, mul_en, div_en
    );

    modport slave (
        input  cu_req, cu_op,
        output cu_done, cu_busy, op_ini_sm, op_act_sm, op_rdy_sm, op_halt_sm,
               add_en, sub_en, mul_en, div_en
    );
`endif

endinterface

// File: rtl/ip_cu_ctrl.sv
// ----------------------------------------------------------------------------
// ip_cu_ctrl -- sequencer for a small arithmetic unit (ADD/SUB/MUL/DIV).
//
// Walks IDLE -> INI -> [ACT x N] -> RDY -> HALT -> IDLE for each request and
// drives state strobes plus one-hot operation enables to an external datapath.
// ADD/SUB skip ACT; MUL spends ALU_SZ cycles and DIV ALU_SZ+EXD_SZ cycles in
// ACT. All outputs come straight from flops.
//
// Parameters:
//   ALU_SZ   datapath arithmetic width (MUL iteration count)
//   EXD_SZ   extended dividend width (extra DIV iterations)
//
// Ports:
//   pclk     pixel clock, sole clock, rising edge
//   prst     synchronous active-high reset
//   cu       ip_cu_ctrl_if.slave bundle (request, opcode, done, busy,
//            state strobes, operation enables)
//
// Optional macro: IP_CU_CTRL_ABORT_EN -- cu_abort sampled in INI or ACT jumps
// straight to HALT (no RDY, no cu_done) and pulses cu_abt for one cycle.
// ----------------------------------------------------------------------------
module ip_cu_ctrl #(
    parameter int ALU_SZ = 8,
    parameter int EXD_SZ = 1
) (
    input  logic          pclk,
    input  logic          prst,
    ip_cu_ctrl_if.slave   cu
);

    localparam int CNT_W = $clog2(ALU_SZ + EXD_SZ + 1);

    localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(ALU_SZ);
    localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(ALU_SZ + EXD_SZ);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INI,
        S_ACT,
        S_RDY,
        S_HALT
    } state_e;

    typedef struct packed {
        logic done;
        logic busy;
        logic ini;
        logic act;
        logic rdy;
        logic halt;
        logic add_en;
        logic sub_en;
        logic mul_en;
        logic div_en;
`ifdef IP_CU_CTRL_ABORT_EN
        logic abt;
`endif
    } out_t;

    state_e           state, state_nx;
    op_e              op_q, op_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    out_t             out_q, out_nx;

    // Number of ACT cycles an opcode needs; zero means go straight to RDY.
    function automatic logic [CNT_W-1:0] act_len(input op_e op);
        case (op)
            OP_MUL:  act_len = MUL_LEN;
            OP_DIV:  act_len = DIV_LEN;
            default: act_len = '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state, counter and next-output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nx = state;
        op_nx    = op_q;
        cnt_nx   = cnt;
        out_nx   = '0;

        unique case (state)
            S_IDLE: begin
                if (cu.cu_req) begin
                    // Opcode is captured here and ignored until back in IDLE.
                    state_nx = S_INI;
                    op_nx    = op_e'(cu.cu_op);
                    cnt_nx   = act_len(op_e'(cu.cu_op));
                end
            end

            S_INI: begin
                if (cnt == '0) begin
                    state_nx = S_RDY;
                end else begin
                    state_nx = S_ACT;
                end
            end

            S_ACT: begin
                // Counter holds N on ACT entry; leaving when it hits 1 gives
                // exactly N ACT cycles and lands RDY with the count at 0.
                cnt_nx = cnt - 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_nx = S_RDY;
                end
            end

            S_RDY: begin
                state_nx = S_HALT;
            end

            S_HALT: begin
                if (!cu.cu_req) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

`ifdef IP_CU_CTRL_ABORT_EN
        // Abort overrides the normal INI/ACT progression and skips RDY.
        if (cu.cu_abort && (state == S_INI || state == S_ACT)) begin
            state_nx   = S_HALT;
            cnt_nx     = '0;
            out_nx.abt = 1'b1;
        end
`endif

        // Outputs are decoded from the next state so they leave flops
        // aligned with the state register.
        out_nx.busy = (state_nx != S_IDLE);
        out_nx.ini  = (state_nx == S_INI);
        out_nx.act  = (state_nx == S_INI) || (state_nx == S_ACT) || (state_nx == S_RDY);
        out_nx.rdy  = (state_nx == S_RDY);
        out_nx.done = (state_nx == S_RDY);
        out_nx.halt = (state_nx == S_HALT);

        if (state_nx != S_IDLE) begin
            out_nx.add_en = (op_nx == OP_ADD);
            out_nx.sub_en = (op_nx == OP_SUB);
            out_nx.mul_en = (op_nx == OP_MUL);
            out_nx.div_en = (op_nx == OP_DIV);
        end
    end

    // ------------------------------------------------------------------
    // State, counter, opcode and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= S_IDLE;
            op_q  <= OP_ADD;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            cnt   <= cnt_nx;
            out_q <= out_nx;
        end
    end

    assign cu.cu_done    = out_q.done;
    assign cu.cu_busy    = out_q.busy;
    assign cu.op_ini_sm  = out_q.ini;
    assign cu.op_act_sm  = out_q.act;
    assign cu.op_rdy_sm  = out_q.rdy;
    assign cu.op_halt_sm = out_q.halt;
    assign cu.add_en     = out_q.add_en;
    assign cu.sub_en     = out_q.sub_en;
    assign cu.mul_en     = out_q.mul_en;
    assign cu.div_en     = out_q.div_en;
`ifdef IP_CU_CTRL_ABORT_EN
    assign cu.cu_abt     = out_q.abt;
`endif

endmodule

// File: tb/tb_ip_cu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ip_cu_ctrl -- self-checking bench for ip_cu_ctrl (ALU_SZ=8, EXD_SZ=1).
//
// A small behavioural datapath (parallel add/sub, shift-add multiply,
// restoring divide) is stepped by the controller's strobes, so a wrong ACT
// length shows up in both the cu_done timing and the computed product.
// Expected done edge and product are queued when a request is driven and
// compared when cu_done appears. Abort coverage is built only when
// IP_CU_CTRL_ABORT_EN is defined.
// ----------------------------------------------------------------------------
module tb_ip_cu_ctrl;

    localparam int ALU_SZ = 8;
    localparam int EXD_SZ = 1;
    localparam int DVD_W  = ALU_SZ + EXD_SZ;

    logic pclk = 1'b0;
    logic prst;

    always #5 pclk = ~pclk;

    ip_cu_ctrl_if cu_bus ();

    ip_cu_ctrl #(
        .ALU_SZ (ALU_SZ),
        .EXD_SZ (EXD_SZ)
    ) dut (
        .pclk (pclk),
        .prst (prst),
        .cu   (cu_bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of rising edges seen so far

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural datapath driven by the controller strobes
    // ------------------------------------------------------------------
    logic [31:0]      num_0, num_1;
    logic [31:0]      res, acc, ma, mb, rem, dvs, q;
    logic [DVD_W-1:0] dvd;
    logic [31:0]      rem_sh;
    logic [31:0]      dp_result;
    logic             act_step;

    assign rem_sh    = {rem[30:0], dvd[DVD_W-1]};
    assign act_step  = cu_bus.op_act_sm && !cu_bus.op_ini_sm && !cu_bus.op_rdy_sm;
    assign dp_result = (cu_bus.add_en || cu_bus.sub_en) ? res :
                       cu_bus.mul_en ? acc : q;

    always @(posedge pclk) begin
        if (prst) begin
            res <= '0;
            acc <= '0;
            q   <= '0;
            rem <= '0;
        end else if (cu_bus.op_ini_sm) begin
            ma  <= num_0;
            mb  <= num_1;
            dvd <= num_0[DVD_W-1:0];
            dvs <= num_1;
            rem <= '0;
            q   <= '0;
            acc <= '0;
            if (cu_bus.add_en) res <= num_0 + num_1;
            else if (cu_bus.sub_en) res <= num_0 - num_1;
        end else if (act_step) begin
            if (cu_bus.mul_en) begin
                acc <= acc + (mb[0] ? ma : 32'd0);
                ma  <= ma << 1;
                mb  <= mb >> 1;
            end
            if (cu_bus.div_en) begin
                dvd <= dvd << 1;
                if (rem_sh >= dvs) begin
                    rem <= rem_sh - dvs;
                    q   <= {q[30:0], 1'b1};
                end else begin
                    rem <= rem_sh;
                    q   <= {q[30:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: expected done edge and product per request
    // ------------------------------------------------------------------
    typedef struct {
        int edge_no;
        int result;
    } exp_t;

    exp_t sb[$];

    always @(negedge pclk) begin
        if (cu_bus.cu_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", cu_bus.cu_done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                // Output seen in this cycle is sampled by the next edge.
                check("done_edge", cyc + 1, e.edge_no);
                check("product", dp_result, e.result);
            end
        end
    end

    logic [9:0] all_out;
    assign all_out = {cu_bus.cu_done, cu_bus.cu_busy, cu_bus.op_ini_sm, cu_bus.op_act_sm,
                      cu_bus.op_rdy_sm, cu_bus.op_halt_sm, cu_bus.add_en, cu_bus.sub_en,
                      cu_bus.mul_en, cu_bus.div_en};

    function automatic logic [3:0] en_vec();
        return {cu_bus.div_en, cu_bus.mul_en, cu_bus.sub_en, cu_bus.add_en};
    endfunction

    // Starts at a falling edge with the controller idle; returns at a falling
    // edge with the controller back in IDLE and cu_req low.
    task automatic do_op(input logic [1:0] op, input int n0, input int n1,
                         input int exp_res, input int hold, input bit drop_early);
        int         k;
        int         lat;
        bit         seen;
        logic [3:0] exp_en;
        exp_t       e;
        exp_en = 4'b0001 << op;
        cu_bus.cu_req = 1'b1;
        cu_bus.cu_op  = op;
        num_0 = n0;
        num_1 = n1;
        k   = cyc + 1;
        lat = (op == 2'd2) ? ALU_SZ + 2 : (op == 2'd3) ? ALU_SZ + EXD_SZ + 2 : 2;
        e.edge_no = k + lat;
        e.result  = exp_res;
        sb.push_back(e);

        @(negedge pclk);
        check("ini_strobe", cu_bus.op_ini_sm, 1'b1);
        check("ini_act", cu_bus.op_act_sm, 1'b1);
        check("ini_busy", cu_bus.cu_busy, 1'b1);
        check("ini_en", en_vec(), exp_en);
        cu_bus.cu_op = ~op;              // must not disturb the latched opcode
        if (drop_early) cu_bus.cu_req = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cu_bus.cu_done === 1'b1) seen = 1'b1;
            else @(negedge pclk);
        end
        check("done_timeout", seen, 1'b1);
        check("rdy_strobe", cu_bus.op_rdy_sm, 1'b1);
        check("rdy_act", cu_bus.op_act_sm, 1'b1);
        check("rdy_en", en_vec(), exp_en);

        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            check("halt_strobe", cu_bus.op_halt_sm, 1'b1);
            check("halt_act", cu_bus.op_act_sm, 1'b0);
            check("halt_en", en_vec(), exp_en);
            if (i == hold - 1) cu_bus.cu_req = 1'b0;
        end

        @(negedge pclk);
        check("idle_outputs", all_out, 10'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        prst          = 1'b1;
        cu_bus.cu_req = 1'b0;
        cu_bus.cu_op  = 2'd0;
`ifdef IP_CU_CTRL_ABORT_EN
        cu_bus.cu_abort = 1'b0;
`endif
        num_0 = '0;
        num_1 = '0;

        repeat (3) @(negedge pclk);
        check("reset_outputs", all_out, 10'd0);
        prst = 1'b0;
        @(negedge pclk);
        check("idle_after_reset", all_out, 10'd0);

        // ADD, SUB, MUL, then back-to-back DIV with a 5-cycle HALT hold.
        do_op(2'd0, 200, 100, 300, 1, 1'b0);
        do_op(2'd1, 50, 20, 30, 2, 1'b0);
        do_op(2'd2, 13, 11, 143, 1, 1'b0);
        do_op(2'd3, 300, 7, 42, 5, 1'b0);

        // cu_req dropped during the operation: it still completes.
        do_op(2'd2, 13, 11, 143, 1, 1'b1);

        // Reset in the 4th ACT cycle of MUL with cu_req held high.
        cu_bus.cu_req = 1'b1;
        cu_bus.cu_op  = 2'd2;
        num_0 = 13;
        num_1 = 11;
        begin
            exp_t e;
            k = cyc + 1;
            e.edge_no = k + ALU_SZ + 2;
            e.result  = 143;
            sb.push_back(e);
        end
        @(negedge pclk);
        repeat (4) @(negedge pclk);
        check("mul_act4_edge", cyc, k + 4);
        check("mul_act4_en", en_vec(), 4'b0100);
        check("mul_act4_ini", cu_bus.op_ini_sm, 1'b0);
        prst = 1'b1;
        sb.delete();
        @(negedge pclk);
        check("mid_reset_outputs", all_out, 10'd0);
        prst = 1'b0;
        // cu_req is still high, so a fresh operation starts from INI.
        do_op(2'd2, 13, 11, 143, 1, 1'b0);

`ifdef IP_CU_CTRL_ABORT_EN
        // Abort in the 2nd ACT cycle of DIV.
        cu_bus.cu_req = 1'b1;
        cu_bus.cu_op  = 2'd3;
        num_0 = 300;
        num_1 = 7;
        k = cyc + 1;
        @(negedge pclk);
        @(negedge pclk);
        @(negedge pclk);
        check("abort_act2_edge", cyc, k + 2);
        cu_bus.cu_abort = 1'b1;
        @(negedge pclk);
        cu_bus.cu_abort = 1'b0;
        check("abort_halt", cu_bus.op_halt_sm, 1'b1);
        check("abort_pulse", cu_bus.cu_abt, 1'b1);
        check("abort_no_done", cu_bus.cu_done, 1'b0);
        check("abort_act", cu_bus.op_act_sm, 1'b0);
        check("abort_en", en_vec(), 4'b1000);
        @(negedge pclk);
        check("abort_pulse_end", cu_bus.cu_abt, 1'b0);
        check("abort_halt_hold", cu_bus.op_halt_sm, 1'b1);
        cu_bus.cu_req = 1'b0;
        @(negedge pclk);
        check("abort_idle", all_out, 10'd0);
`endif

        repeat (3) @(negedge pclk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
